// File: rtl/cpu_bus_controller.sv
// cpu_bus_controller
// Bus-cycle controller between a 68000 CPU and board PROM/SRAM.
//   - Generates CPUCLK = MCLK/2.
//   - Registers the CPU strobes and A23..A20, then decodes each bus cycle
//     onto active-low PROM/SRAM byte chip selects.
//   - Inserts per-region wait states before DTACK_N.
//   - Ends unmapped cycles and PROM writes with BERR_N after a timeout.
//   - Single-step: with STEPEN high, DTACK_N is held off until a debounced
//     STEP press.
// Ports:
//   MCLK, RESET_N           clock, async active-low reset
//   AS_N, UDS_N, LDS_N, RW  CPU bus strobes and direction
//   A[3:0]                  CPU address bits A23..A20
//   STEP, STEPEN            raw step button, step-mode enable
//   CPUCLK                  CPU clock
//   SRAMCS0/1, PROMCS0/1    byte chip selects, active low (0 = upper, 1 = lower)
//   DTACK_N, BERR_N         cycle termination, active low
//   RUN                     1 = CPU not held in step
// All outputs are registered.
module cpu_bus_controller #(
  parameter int unsigned PROM_WAIT    = 2,
  parameter int unsigned SRAM_WAIT    = 0,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter int unsigned DEBOUNCE     = 16
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic       AS_N,
  input  logic       UDS_N,
  input  logic       LDS_N,
  input  logic       RW,
  input  logic [3:0] A,
  input  logic       STEP,
  input  logic       STEPEN,
  output logic       CPUCLK,
  output logic       SRAMCS0,
  output logic       SRAMCS1,
  output logic       PROMCS0,
  output logic       PROMCS1,
  output logic       DTACK_N,
  output logic       BERR_N,
  output logic       RUN
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] PROM_N  = CW'(PROM_WAIT);
  localparam logic [CW-1:0] SRAM_N  = CW'(SRAM_WAIT);
  localparam logic [CW-1:0] BERR_N_CYC = CW'(BERR_TIMEOUT);
  localparam logic [CW-1:0] DEB_N   = CW'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_STEPHOLD,
    S_ACK,
    S_TIMEOUT,
    S_BERRS
  } state_e;

  // Registered CPU bus inputs
  logic          as_q, uds_q, lds_q, rw_q;
  logic [3:0]    a_q;

  // FSM and counters
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // STEP synchronizer and debouncer
  logic          sync1_q, sync2_q;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic          step_lvl_q, step_lvl_d;
  logic          step_pulse_q, step_pulse_d;

  // Registered outputs
  logic          cpuclk_q, cpuclk_d;
  logic          sramcs0_q, sramcs0_d;
  logic          sramcs1_q, sramcs1_d;
  logic          promcs0_q, promcs0_d;
  logic          promcs1_q, promcs1_d;
  logic          dtack_n_q, dtack_n_d;
  logic          berr_n_q, berr_n_d;
  logic          run_q, run_d;

  // Decode helpers
  logic          is_prom, is_sram, mapped, cs_active;
  logic [CW-1:0] region_wait;
  state_e        ack_or_hold;

  // Region decode; a PROM write counts as unmapped
  always_comb begin
    is_prom     = (a_q == 4'h0) && rw_q;
    is_sram     = (a_q == 4'h1);
    mapped      = is_prom || is_sram;
    region_wait = is_prom ? PROM_N : SRAM_N;
    ack_or_hold = STEPEN ? S_STEPHOLD : S_ACK;
  end

  // STEP debounce: accept a new level after DEBOUNCE consecutive differing samples
  always_comb begin
    db_cnt_d     = '0;
    step_lvl_d   = step_lvl_q;
    step_pulse_d = 1'b0;
    if (sync2_q != step_lvl_q) begin
      if (db_cnt_q + CW'(1) >= DEB_N) begin
        step_lvl_d   = sync2_q;
        step_pulse_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  // Bus-cycle FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!as_q) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (as_q) begin
          state_d = S_IDLE;
        end else if (!mapped) begin
          // TIMEOUT leaves on the edge its count reaches 0, so BERR_N
          // lands BERR_TIMEOUT edges after DECODE.
          if (BERR_N_CYC <= CW'(1)) begin
            state_d = S_BERRS;
          end else begin
            state_d = S_TIMEOUT;
            cnt_d   = BERR_N_CYC - CW'(1);
          end
        end else if (region_wait <= CW'(1)) begin
          // One wait state is already covered by the DECODE cycle
          state_d = ack_or_hold;
        end else begin
          state_d = S_WAIT;
          cnt_d   = region_wait - CW'(1);
        end
      end
      S_WAIT: begin
        if (as_q) begin
          state_d = S_IDLE;
        end else if (cnt_q <= CW'(1)) begin
          state_d = ack_or_hold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STEPHOLD: begin
        if (as_q) begin
          state_d = S_IDLE;
        end else if (step_pulse_q || !STEPEN) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (as_q) state_d = S_IDLE;
      end
      S_TIMEOUT: begin
        if (as_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CW'(1)) begin
          state_d = S_BERRS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BERRS: begin
        if (as_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge as the FSM
  always_comb begin
    cpuclk_d  = ~cpuclk_q;
    cs_active = mapped && ((state_d == S_DECODE) || (state_d == S_WAIT) ||
                           (state_d == S_STEPHOLD) || (state_d == S_ACK));
    promcs0_d = !(cs_active && is_prom && !uds_q);
    promcs1_d = !(cs_active && is_prom && !lds_q);
    sramcs0_d = !(cs_active && is_sram && !uds_q);
    sramcs1_d = !(cs_active && is_sram && !lds_q);
    dtack_n_d = (state_d != S_ACK);
    berr_n_d  = (state_d != S_BERRS);
    run_d     = (state_d != S_STEPHOLD);
  end

  // State, input and output registers
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      as_q         <= 1'b1;
      uds_q        <= 1'b1;
      lds_q        <= 1'b1;
      rw_q         <= 1'b1;
      a_q          <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      step_lvl_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      cpuclk_q     <= 1'b0;
      sramcs0_q    <= 1'b1;
      sramcs1_q    <= 1'b1;
      promcs0_q    <= 1'b1;
      promcs1_q    <= 1'b1;
      dtack_n_q    <= 1'b1;
      berr_n_q     <= 1'b1;
      run_q        <= 1'b1;
    end else begin
      as_q         <= AS_N;
      uds_q        <= UDS_N;
      lds_q        <= LDS_N;
      rw_q         <= RW;
      a_q          <= A;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= STEP;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      step_lvl_q   <= step_lvl_d;
      step_pulse_q <= step_pulse_d;
      cpuclk_q     <= cpuclk_d;
      sramcs0_q    <= sramcs0_d;
      sramcs1_q    <= sramcs1_d;
      promcs0_q    <= promcs0_d;
      promcs1_q    <= promcs1_d;
      dtack_n_q    <= dtack_n_d;
      berr_n_q     <= berr_n_d;
      run_q        <= run_d;
    end
  end

  assign CPUCLK  = cpuclk_q;
  assign SRAMCS0 = sramcs0_q;
  assign SRAMCS1 = sramcs1_q;
  assign PROMCS0 = promcs0_q;
  assign PROMCS1 = promcs1_q;
  assign DTACK_N = dtack_n_q;
  assign BERR_N  = berr_n_q;
  assign RUN     = run_q;

endmodule
